fu_reservation_station: RTL
===========================

Name: fu_reservation_station

Overview:
- Single-entry reservation station for one functional unit. It sits on the consumer/producer side of the retirement bus.
- It accepts a dispatched instruction with operands that are either values or producer tags. It snoops the broadcast bus to capture pending operands, issues to its functional unit, and buffers the result.
- It raises `retirement_ready_o` until the retirement arbiter grants this unit. That grant is the retire strobe plus a matching unit ID.

Parameters:
- DATA_WIDTH, 64, operand and result width.
- TAG_WIDTH, 3, width of producer tag / functional-unit ID. Equals `$clog2(FU_CNT)`.
- OP_WIDTH, 4, opcode width, passed through unmodified.
- UNIT_ID, 0, this station's functional-unit ID; matched against `unit_retire_i`.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous squash of the held instruction
- dispatch_valid_i  in  1  dispatch request
- dispatch_ready_o  out  1  station free, can accept dispatch
- dispatch_op_i  in  OP_WIDTH  opcode
- dispatch_a_valid_i / dispatch_b_valid_i  in  1  operand holds a value (1) or a tag (0)
- dispatch_a_i / dispatch_b_i  in  DATA_WIDTH  operand value; low TAG_WIDTH bits are the producer tag when not valid
- issue_valid_o  out  1  operands complete, request execution
- issue_ready_i  in  1  functional unit accepts
- issue_op_o  out  OP_WIDTH  held opcode
- issue_a_o / issue_b_o  out  DATA_WIDTH  held operand values
- result_valid_i  in  1  functional unit result strobe
- result_i  in  DATA_WIDTH  functional unit result
- bcast_valid_i  in  1  retirement broadcast valid
- bcast_tag_i  in  TAG_WIDTH  ID of the retiring unit
- bcast_value_i  in  DATA_WIDTH  broadcast value
- retirement_ready_o  out  1  result held, requesting retirement
- unit_result_o  out  DATA_WIDTH  held result
- retire_en_i  in  1  arbiter retire strobe
- unit_retire_i  in  TAG_WIDTH  unit selected by the arbiter

Behaviour:
- States: FREE, WAIT_OPS, ISSUED, DONE, DRAIN.
- Reset (async, rst_ni=0):
  - state=FREE; all operand, opcode and result registers 0; operand-valid flags 0.
  - Outputs: dispatch_ready_o=1, issue_valid_o=0, retirement_ready_o=0, issue_op_o/issue_a_o/issue_b_o/unit_result_o=0.
- dispatch_ready_o = (state==FREE). All other outputs are decoded from registered state/fields.
- FREE, on dispatch_valid_i:
  - Capture op, both operands and both valid flags; go to WAIT_OPS.
  - Same-cycle bypass: if an operand is a tag, bcast_valid_i=1 and bcast_tag_i equals that tag, latch bcast_value_i instead and set its flag.
- WAIT_OPS:
  - Each cycle, for each operand not yet valid, capture bcast_value_i on a tag match and set its flag. Both operands may capture in the same cycle.
  - issue_valid_o = both flags set. It asserts the cycle after the last operand becomes valid; with no pending operands at dispatch, that is the cycle after dispatch.
  - issue_valid_o holds and operands stay stable until issue_ready_i. On the handshake, go to ISSUED.
- ISSUED: on result_valid_i, latch result_i and go to DONE. result_valid_i is ignored in all other states except DRAIN.
- DONE: retirement_ready_o=1 and unit_result_o=result; both are held stable until retire_en_i && unit_retire_i==UNIT_ID, then go to FREE.
  - A grant to another unit is ignored.
  - No same-cycle dispatch: dispatch_ready_o=0 in DONE.
- flush_i has priority over every other event:
  - FREE, WAIT_OPS or DONE: go to FREE next cycle. Any retire grant in the same cycle is honoured as a release (go to FREE); the flag is cleared either way.
  - ISSUED: go to DRAIN. DRAIN waits for result_valid_i, discards it, then goes to FREE. flush_i in DRAIN has no further effect.
  - A dispatch_valid_i coinciding with flush_i in FREE is dropped.
- Tag match compares the full TAG_WIDTH bits only; upper operand bits are ignored while a flag is clear.
- Result latency from result_valid_i to retirement_ready_o is 1 cycle. Minimum dispatch-to-FREE is 4 cycles (dispatch, issue, result, retire).
- Reset asserted mid-operation returns immediately to FREE with the reset values above, asynchronously.

Test Plan:
- Ready operands: dispatch a=5, b=7 (both valid), issue_ready_i=1, result 12 one cycle later -> issue_valid_o at cycle+1; retirement_ready_o=1, unit_result_o=12 until retire_en_i with unit_retire_i=UNIT_ID, then dispatch_ready_o=1.
- Tag wakeup: dispatch a=tag 3, b=9; broadcast tag 2 value 99 (ignored), then tag 3 value 0x1234 -> issue_a_o=0x1234, issue_b_o=9; issue_valid_o only after the tag-3 cycle.
- Bypass + dual capture: dispatch a=tag 1 with concurrent broadcast tag 1 value 40 -> captured at dispatch. Separately, dispatch a=tag 4, b=tag 4, then broadcast tag 4 value 8 -> both operands 8 in one cycle.
- Retire arbitration: in DONE, retire_en_i=1 with unit_retire_i≠UNIT_ID for 3 cycles -> retirement_ready_o stays 1 and result is unchanged; matching grant -> FREE next cycle.
- Flush in flight: flush_i in ISSUED -> DRAIN. A later result_valid_i with 0xDEAD is discarded, state is FREE, and retirement_ready_o is never asserted. flush_i in WAIT_OPS -> FREE next cycle.
- Async reset in DONE mid-cycle -> retirement_ready_o=0, dispatch_ready_o=1 immediately, unit_result_o=0.

Source files
------------

// File: rtl/fu_reservation_station.sv
// Single-entry reservation station for one functional unit.
// Holds one dispatched instruction and snoops the retirement broadcast bus for
// any operand that arrived as a producer tag. Once both operands are present,
// it issues the instruction to its functional unit. It then buffers the result
// and requests retirement until the arbiter grants this unit.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                synchronous squash of the held instruction
//   dispatch_*             dispatch handshake, opcode and operands (value or tag)
//   issue_*                issue handshake and held opcode/operands to the FU
//   result_valid_i/result_i  FU result strobe and value
//   bcast_*                retirement broadcast (tag = retiring unit ID, value)
//   retirement_ready_o     result held, requesting retirement
//   unit_result_o          held result
//   retire_en_i/unit_retire_i  arbiter grant strobe and selected unit
module fu_reservation_station #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned TAG_WIDTH  = 3,
   parameter int unsigned OP_WIDTH   = 4,
   parameter int unsigned UNIT_ID    = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  dispatch_valid_i,
   output logic                  dispatch_ready_o,
   input  logic [OP_WIDTH-1:0]   dispatch_op_i,
   input  logic                  dispatch_a_valid_i,
   input  logic                  dispatch_b_valid_i,
   input  logic [DATA_WIDTH-1:0] dispatch_a_i,
   input  logic [DATA_WIDTH-1:0] dispatch_b_i,
   output logic                  issue_valid_o,
   input  logic                  issue_ready_i,
   output logic [OP_WIDTH-1:0]   issue_op_o,
   output logic [DATA_WIDTH-1:0] issue_a_o,
   output logic [DATA_WIDTH-1:0] issue_b_o,
   input  logic                  result_valid_i,
   input  logic [DATA_WIDTH-1:0] result_i,
   input  logic                  bcast_valid_i,
   input  logic [TAG_WIDTH-1:0]  bcast_tag_i,
   input  logic [DATA_WIDTH-1:0] bcast_value_i,
   output logic                  retirement_ready_o,
   output logic [DATA_WIDTH-1:0] unit_result_o,
   input  logic                  retire_en_i,
   input  logic [TAG_WIDTH-1:0]  unit_retire_i
);

   localparam logic [2:0] FREE     = 3'd0;
   localparam logic [2:0] WAIT_OPS = 3'd1;
   localparam logic [2:0] ISSUED   = 3'd2;
   localparam logic [2:0] DONE     = 3'd3;
   localparam logic [2:0] DRAIN    = 3'd4;

   localparam logic [TAG_WIDTH-1:0] UNIT_TAG = TAG_WIDTH'(UNIT_ID);

   logic [2:0]            state_q, state_d;
   logic [OP_WIDTH-1:0]   op_q, op_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic                  a_ok_q, a_ok_d, b_ok_q, b_ok_d;

   logic grant;
   logic a_hit_disp, b_hit_disp;
   logic a_hit, b_hit;
   logic ops_ready;

   // Arbiter grant addressed to this unit
   assign grant = retire_en_i && (unit_retire_i == UNIT_TAG);

   // Same-cycle bypass of a broadcast into a tagged operand at dispatch
   assign a_hit_disp = !dispatch_a_valid_i && bcast_valid_i &&
                       (bcast_tag_i == dispatch_a_i[TAG_WIDTH-1:0]);
   assign b_hit_disp = !dispatch_b_valid_i && bcast_valid_i &&
                       (bcast_tag_i == dispatch_b_i[TAG_WIDTH-1:0]);

   // Wakeup of a held tagged operand; the tag lives in the low operand bits
   assign a_hit = !a_ok_q && bcast_valid_i && (bcast_tag_i == a_q[TAG_WIDTH-1:0]);
   assign b_hit = !b_ok_q && bcast_valid_i && (bcast_tag_i == b_q[TAG_WIDTH-1:0]);

   assign ops_ready = a_ok_q && b_ok_q;

   // Outputs decoded from registered state and fields
   assign dispatch_ready_o   = (state_q == FREE);
   assign issue_valid_o      = (state_q == WAIT_OPS) && ops_ready;
   assign retirement_ready_o = (state_q == DONE);
   assign issue_op_o         = op_q;
   assign issue_a_o          = a_q;
   assign issue_b_o          = b_q;
   assign unit_result_o      = res_q;

   // State and field registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= FREE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         a_ok_q  <= 1'b0;
         b_ok_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         a_ok_q  <= a_ok_d;
         b_ok_q  <= b_ok_d;
      end
   end

   // Next-state and field update; flush takes priority in every state
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      a_ok_d  = a_ok_q;
      b_ok_d  = b_ok_q;

      case (state_q)
         FREE: begin
            if (!flush_i && dispatch_valid_i) begin
               op_d    = dispatch_op_i;
               a_d     = a_hit_disp ? bcast_value_i : dispatch_a_i;
               b_d     = b_hit_disp ? bcast_value_i : dispatch_b_i;
               a_ok_d  = dispatch_a_valid_i || a_hit_disp;
               b_ok_d  = dispatch_b_valid_i || b_hit_disp;
               state_d = WAIT_OPS;
            end
         end
         WAIT_OPS: begin
            if (flush_i) begin
               a_ok_d  = 1'b0;
               b_ok_d  = 1'b0;
               state_d = FREE;
            end else begin
               if (a_hit) begin
                  a_d    = bcast_value_i;
                  a_ok_d = 1'b1;
               end
               if (b_hit) begin
                  b_d    = bcast_value_i;
                  b_ok_d = 1'b1;
               end
               if (ops_ready && issue_ready_i) begin
                  state_d = ISSUED;
               end
            end
         end
         ISSUED: begin
            if (flush_i) begin
               // A result arriving with the flush leaves nothing in flight to drain
               state_d = result_valid_i ? FREE : DRAIN;
            end else if (result_valid_i) begin
               res_d   = result_i;
               state_d = DONE;
            end
         end
         DONE: begin
            if (flush_i || grant) begin
               state_d = FREE;
            end
         end
         DRAIN: begin
            if (result_valid_i) begin
               state_d = FREE;
            end
         end
         default: begin
            state_d = FREE;
         end
      endcase
   end

endmodule
